// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/UART sequencer and the ALU it drives:
// state encoding, default widths and the opcode map.
package alu_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
   localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
   localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
   localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
   localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
   localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
   localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;
   localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Bundle of UART RX/TX, ALU operand and status signals seen by the sequencer.
interface alu_uart_ctrl_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
);
   logic [NB_DATA-1:0] rx_data;
   logic               rx_valid;
   logic [NB_DATA-1:0] data_a;
   logic [NB_DATA-1:0] data_b;
   logic [NB_OP-1:0]   op;
   logic [NB_DATA-1:0] alu_result;
   logic [NB_DATA-1:0] tx_data;
   logic               tx_start;
   logic               tx_done;
   logic               busy;
   logic               err;

   modport master (
      input  rx_data, rx_valid, alu_result, tx_done,
      output data_a, data_b, op, tx_data, tx_start, busy, err
   );

   modport slave (
      output rx_data, rx_valid, alu_result, tx_done,
      input  data_a, data_b, op, tx_data, tx_start, busy, err
   );
endinterface

// File: rtl/tmo_counter.sv
// Inter-byte timeout counter: counts while enabled, flags the last allowed
// cycle so the owner can abort; clear has priority over counting.
module tmo_counter #(
   parameter int TIMEOUT_CYC = 1000000,
   parameter int NB_TMO      = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);
   localparam logic [NB_TMO-1:0] LAST = NB_TMO'(TIMEOUT_CYC - 1);

   logic [NB_TMO-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + NB_TMO'(1);
      end
   end

   assign expire = en && (cnt == LAST);
endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer: gathers A, B, opcode from UART RX, lets the ALU settle one
// cycle, then hands the result to UART TX and waits for completion.
//
// state      | meaning
// WAIT_A     | idle, next byte is operand A
// WAIT_B     | A held, waiting for operand B (timeout armed)
// WAIT_OP    | A/B held, waiting for opcode (timeout armed)
// SETTLE     | operands stable at ALU inputs; raise tx_start for next cycle
// SEND       | tx_start high, capture ALU result into tx_data
// WAIT_TX    | waiting for tx_done from the transmitter
module alu_uart_ctrl
   import alu_pkg::*;
#(
   parameter int NB_DATA     = NB_DATA_DEF,
   parameter int NB_OP       = NB_OP_DEF,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int NB_TMO      = 20
) (
   input  logic           clk,
   input  logic           i_rst_n,
   alu_uart_ctrl_if.master bus
);
   state_t state;
   logic   tmo_en;
   logic   tmo_clr;
   logic   tmo_exp;

   assign tmo_en  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
   assign tmo_clr = bus.rx_valid || !tmo_en || tmo_exp;

   tmo_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .NB_TMO      (NB_TMO)
   ) u_tmo (
      .clk    (clk),
      .rst_n  (i_rst_n),
      .en     (tmo_en),
      .clr    (tmo_clr),
      .expire (tmo_exp)
   );

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_WAIT_A;
         bus.data_a   <= '0;
         bus.data_b   <= '0;
         bus.op       <= '0;
         bus.tx_data  <= '0;
         bus.tx_start <= 1'b0;
         bus.err      <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         bus.tx_start <= 1'b0;
         bus.err      <= 1'b0;
         case (state)
            ST_WAIT_A: begin
               if (bus.rx_valid) begin
                  bus.data_a <= bus.rx_data;
                  state      <= ST_WAIT_B;
                  bus.busy   <= 1'b1;
               end
            end
            // A byte arriving on the expiry cycle wins over the abort.
            ST_WAIT_B: begin
               if (bus.rx_valid) begin
                  bus.data_b <= bus.rx_data;
                  state      <= ST_WAIT_OP;
               end else if (tmo_exp) begin
                  state    <= ST_WAIT_A;
                  bus.err  <= 1'b1;
                  bus.busy <= 1'b0;
               end
            end
            ST_WAIT_OP: begin
               if (bus.rx_valid) begin
                  bus.op <= bus.rx_data[NB_OP-1:0];
                  state  <= ST_SETTLE;
               end else if (tmo_exp) begin
                  state    <= ST_WAIT_A;
                  bus.err  <= 1'b1;
                  bus.busy <= 1'b0;
               end
            end
            ST_SETTLE: begin
               bus.tx_start <= 1'b1;
               state        <= ST_SEND;
            end
            ST_SEND: begin
               bus.tx_data <= bus.alu_result[NB_DATA-1:0];
               state       <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (bus.tx_done) begin
                  state    <= ST_WAIT_A;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= ST_WAIT_A;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl with a behavioural ALU and TX stub.
module tb_alu_uart_ctrl;
   import alu_pkg::*;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_start = 0;
   int   n_err = 0;
   int   op_cyc = 0;
   bit   lat_armed = 1'b0;
   bit   pending = 1'b0;
   logic [7:0] exp_q[$];

   alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

   alu_uart_ctrl #(
      .NB_DATA     (8),
      .NB_OP       (6),
      .TIMEOUT_CYC (TMO),
      .NB_TMO      (5)
   ) dut (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [5:0] op);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SRA:  return sa >>> b[2:0];
         OP_SRL:  return a >> b[2:0];
         OP_NOR:  return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   assign bus.alu_result = alu_ref(bus.data_a, bus.data_b, bus.op);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.err) n_err++;
      if (pending) begin
         pending = 1'b0;
         if (exp_q.size() == 0) chk("unexpected_tx", 32'(exp_q.size()), 1);
         else chk("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
      if (bus.tx_start) begin
         n_start++;
         pending = 1'b1;
         if (lat_armed) begin
            lat_armed = 1'b0;
            chk("start_latency", 32'(cyc - op_cyc), 2);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit is_op = 1'b0);
      @(posedge clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      if (is_op) begin
         op_cyc    = cyc;
         lat_armed = 1'b1;
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input int gap = 0, input bit inject = 1'b0);
      int s0;
      s0 = n_start;
      send_byte(a);
      repeat (gap) @(posedge clk);
      send_byte(b);
      exp_q.push_back(alu_ref(a, b, op));
      send_byte({2'b00, op}, 1'b1);
      for (int i = 0; i < 10 && n_start == s0; i++) @(posedge clk);
      chk("start_seen", 32'(n_start), 32'(s0 + 1));
      if (inject) begin
         send_byte(8'h77);
         send_byte(8'h88);
         chk("drop_keep_a", 32'(bus.data_a), 32'(a));
      end
      @(negedge clk);
      chk("busy_wait_tx", 32'(bus.busy), 1);
      @(posedge clk); #1;
      bus.tx_done = 1'b1;
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
      @(negedge clk);
      chk("busy_done", 32'(bus.busy), 0);
      chk("single_start", 32'(n_start), 32'(s0 + 1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data_a"},  32'(bus.data_a), 0);
      chk({tag, "_data_b"},  32'(bus.data_b), 0);
      chk({tag, "_op"},      32'(bus.op), 0);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
      chk({tag, "_start"},   32'(bus.tx_start), 0);
      chk({tag, "_err"},     32'(bus.err), 0);
      chk({tag, "_busy"},    32'(bus.busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops [8];
      int e0;
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.tx_done  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;

      frame(8'h05, 8'h03, OP_ADD);
      frame(8'h02, 8'h05, OP_SUB);

      // timeout abort after operand A
      e0 = n_err;
      send_byte(8'h11);
      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("tmo_early", 32'(n_err), 32'(e0));
      repeat (5) @(posedge clk);
      #1;
      chk("tmo_err_pulses", 32'(n_err), 32'(e0 + 1));
      chk("tmo_busy", 32'(bus.busy), 0);
      chk("tmo_keep_a", 32'(bus.data_a), 32'h11);
      frame(8'h01, 8'h01, OP_ADD);

      // operand B strobed on the exact expiry cycle
      e0 = n_err;
      frame(8'h21, 8'h13, OP_AND, TMO - 2);
      chk("edge_no_err", 32'(n_err), 32'(e0));
      chk("edge_b", 32'(bus.data_b), 32'h13);

      // bytes during WAIT_TX are dropped
      e0 = n_err;
      frame(8'h33, 8'h44, OP_XOR, 0, 1'b1);
      frame(8'h0F, 8'hF0, OP_OR);
      chk("drop_no_err", 32'(n_err), 32'(e0));

      // reset mid-frame
      send_byte(8'h12);
      send_byte(8'h34);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      frame(8'hAA, 8'h55, OP_XOR);

      for (int i = 0; i < 6; i++) begin
         frame(8'($urandom), 8'($urandom), ops[$urandom_range(0, 7)]);
      end

      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
